// File: rtl/elevator_pkg.sv
// rtl/elevator_pkg.sv - shared widths, direction codes and scan states for the call register
package elevator_pkg;

    localparam int BUTTONS_WIDTH = 6;

    localparam logic [1:0] DIR_STOP = 2'b00;
    localparam logic [1:0] DIR_UP   = 2'b01;
    localparam logic [1:0] DIR_DOWN = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_UP   = 2'b01,
        ST_DOWN = 2'b10
    } scan_state_e;

endpackage

// File: rtl/btn_sync_edge.sv
// rtl/btn_sync_edge.sv - two-flop synchroniser plus rising-edge pulse for a button vector
module btn_sync_edge #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] raw_i,
    output logic [WIDTH-1:0] rise_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] prev_q;
    logic [1:0]       warm_q;
    logic             armed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
            prev_q <= '0;
            warm_q <= 2'd0;
        end else begin
            meta_q <= raw_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
            if (warm_q != 2'd3) begin
                warm_q <= warm_q + 2'd1;
            end
        end
    end

    // Edges stay masked until the pipe has refilled, so a button held through reset is not seen as a press.
    assign armed  = (warm_q == 2'd3);
    assign rise_o = armed ? (sync_q & ~prev_q) : '0;

endmodule

// File: rtl/elevator_call_register.sv
// rtl/elevator_call_register.sv - latches car/hall calls and runs the collective up/down scan
module elevator_call_register #(
    parameter int BUTTONS_WIDTH = elevator_pkg::BUTTONS_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [BUTTONS_WIDTH-1:0] btn_num_in,
    input  logic [BUTTONS_WIDTH-1:0] btn_up_out,
    input  logic [BUTTONS_WIDTH-1:0] btn_down_out,
    input  logic [BUTTONS_WIDTH-1:0] floor_onehot,
    input  logic                     door_open,
    output logic [BUTTONS_WIDTH-1:0] pend_car,
    output logic [BUTTONS_WIDTH-1:0] pend_up,
    output logic [BUTTONS_WIDTH-1:0] pend_down,
    output logic [1:0]               dir_req,
    output logic                     call_here,
    output logic                     any_pending
);

    import elevator_pkg::*;

    localparam int W = BUTTONS_WIDTH;
    localparam logic [W-1:0] ONE      = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] UP_VALID = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] DN_VALID = {{(W-1){1'b1}}, 1'b0};

    logic [W-1:0] edge_car, edge_up_raw, edge_dn_raw;
    logic [W-1:0] edge_up, edge_dn;

    logic [W-1:0] car_q, car_d;
    logic [W-1:0] up_q,  up_d;
    logic [W-1:0] dn_q,  dn_d;
    scan_state_e  state_q;

    logic         floor_valid;
    logic [W-1:0] mask_below, mask_above;
    logic [W-1:0] all_req;
    logic         req_above, req_below;
    logic         up_ok, dn_ok, svc, here;
    logic [W-1:0] clr_car, clr_up, clr_dn;

    btn_sync_edge #(.WIDTH(W)) u_sync_car (
        .clk    (clk),
        .rst_n  (reset),
        .raw_i  (btn_num_in),
        .rise_o (edge_car)
    );

    btn_sync_edge #(.WIDTH(W)) u_sync_up (
        .clk    (clk),
        .rst_n  (reset),
        .raw_i  (btn_up_out),
        .rise_o (edge_up_raw)
    );

    btn_sync_edge #(.WIDTH(W)) u_sync_dn (
        .clk    (clk),
        .rst_n  (reset),
        .raw_i  (btn_down_out),
        .rise_o (edge_dn_raw)
    );

    // No up call exists at the top floor and no down call at the bottom floor.
    assign edge_up = edge_up_raw & UP_VALID;
    assign edge_dn = edge_dn_raw & DN_VALID;

    assign floor_valid = (floor_onehot != '0) && ((floor_onehot & (floor_onehot - ONE)) == '0);
    assign mask_below  = floor_onehot - ONE;
    assign mask_above  = ~(floor_onehot | mask_below);

    assign all_req   = car_q | up_q | dn_q;
    assign req_above = floor_valid && ((all_req & mask_above) != '0);
    assign req_below = floor_valid && ((all_req & mask_below) != '0);

    // Hall calls are only answered when travelling their way, or when idle.
    assign up_ok = (state_q != ST_DOWN);
    assign dn_ok = (state_q != ST_UP);
    assign svc   = floor_valid && door_open;

    assign here = ((car_q & floor_onehot) != '0)
               || (up_ok && ((up_q & floor_onehot) != '0))
               || (dn_ok && ((dn_q & floor_onehot) != '0));

    assign clr_car = svc           ? floor_onehot : '0;
    assign clr_up  = (svc && up_ok) ? floor_onehot : '0;
    assign clr_dn  = (svc && dn_ok) ? floor_onehot : '0;

    assign car_d = (car_q | edge_car) & ~clr_car;
    assign up_d  = (up_q  | edge_up)  & ~clr_up;
    assign dn_d  = (dn_q  | edge_dn)  & ~clr_dn;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            car_q <= '0;
            up_q  <= '0;
            dn_q  <= '0;
        end else begin
            car_q <= car_d;
            up_q  <= up_d;
            dn_q  <= dn_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else if (floor_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (req_above)      state_q <= ST_UP;
                    else if (req_below) state_q <= ST_DOWN;
                    else                state_q <= ST_IDLE;
                end
                ST_UP: begin
                    if (req_above)      state_q <= ST_UP;
                    else if (req_below) state_q <= ST_DOWN;
                    else                state_q <= ST_IDLE;
                end
                ST_DOWN: begin
                    if (req_below)      state_q <= ST_DOWN;
                    else if (req_above) state_q <= ST_UP;
                    else                state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        dir_req = DIR_STOP;
        if (floor_valid && !here) begin
            case (state_q)
                ST_UP:   dir_req = DIR_UP;
                ST_DOWN: dir_req = DIR_DOWN;
                default: dir_req = DIR_STOP;
            endcase
        end
    end

    assign call_here   = floor_valid && here;
    assign any_pending = (all_req != '0);
    assign pend_car    = car_q;
    assign pend_up     = up_q;
    assign pend_down   = dn_q;

endmodule

// File: tb/tb_elevator_call_register.sv
// tb/tb_elevator_call_register.sv - directed self-checking bench for elevator_call_register
module tb_elevator_call_register;

    logic       clk;
    logic       reset;
    logic [5:0] btn_num_in;
    logic [5:0] btn_up_out;
    logic [5:0] btn_down_out;
    logic [5:0] floor_onehot;
    logic       door_open;
    logic [5:0] pend_car;
    logic [5:0] pend_up;
    logic [5:0] pend_down;
    logic [1:0] dir_req;
    logic       call_here;
    logic       any_pending;

    int checks = 0;
    int errors = 0;

    elevator_call_register #(.BUTTONS_WIDTH(6)) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_num_in   (btn_num_in),
        .btn_up_out   (btn_up_out),
        .btn_down_out (btn_down_out),
        .floor_onehot (floor_onehot),
        .door_open    (door_open),
        .pend_car     (pend_car),
        .pend_up      (pend_up),
        .pend_down    (pend_down),
        .dir_req      (dir_req),
        .call_here    (call_here),
        .any_pending  (any_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset        = 1'b0;
        btn_num_in   = '0;
        btn_up_out   = '0;
        btn_down_out = '0;
        floor_onehot = 6'b000001;
        door_open    = 1'b0;

        // reset with buttons toggling
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            btn_num_in   = 6'(i * 11);
            btn_up_out   = 6'(i * 7);
            btn_down_out = 6'(i * 13);
        end
        check("rst_pend_car", 32'(pend_car), 32'h0);
        check("rst_pend_up", 32'(pend_up), 32'h0);
        check("rst_pend_down", 32'(pend_down), 32'h0);
        check("rst_dir", 32'(dir_req), 32'h0);
        check("rst_any", 32'(any_pending), 32'h0);
        check("rst_here", 32'(call_here), 32'h0);

        // held across release must not latch
        btn_num_in   = 6'b000100;
        btn_up_out   = '0;
        btn_down_out = '0;
        tick(1);
        reset = 1'b1;
        tick(6);
        check("held_no_latch", 32'(pend_car), 32'h0);
        btn_num_in = '0;
        tick(3);

        // car call above, latency
        floor_onehot = 6'b000001;
        btn_num_in = 6'b001000;
        tick(1);
        btn_num_in = '0;
        tick(1);
        check("lat_k1", 32'(pend_car), 32'h0);
        tick(1);
        check("lat_k2", 32'(pend_car), 32'h08);
        check("lat_any", 32'(any_pending), 32'h1);
        check("lat_dir_idle", 32'(dir_req), 32'h0);
        tick(1);
        check("dir_up", 32'(dir_req), 32'h1);

        // service and clear
        floor_onehot = 6'b001000;
        #1;
        check("svc_here", 32'(call_here), 32'h1);
        check("svc_dir", 32'(dir_req), 32'h0);
        door_open = 1'b1;
        tick(1);
        check("svc_clear", 32'(pend_car), 32'h0);
        check("svc_any", 32'(any_pending), 32'h0);
        check("svc_dir_idle", 32'(dir_req), 32'h0);
        door_open = 1'b0;

        // held button latches once
        floor_onehot = 6'b000001;
        btn_num_in = 6'b010000;
        tick(3);
        check("hold_latch", 32'(pend_car), 32'h10);
        floor_onehot = 6'b010000;
        door_open = 1'b1;
        tick(1);
        check("hold_clear", 32'(pend_car), 32'h0);
        door_open = 1'b0;
        tick(5);
        check("hold_once", 32'(pend_car), 32'h0);
        btn_num_in = '0;
        tick(3);

        // directional hall clear at floor 2 while travelling up
        floor_onehot = 6'b000100;
        btn_num_in   = 6'b100000;
        btn_up_out   = 6'b000100;
        btn_down_out = 6'b000100;
        tick(1);
        btn_num_in   = '0;
        btn_up_out   = '0;
        btn_down_out = '0;
        tick(2);
        check("hall_up_set", 32'(pend_up), 32'h04);
        check("hall_dn_set", 32'(pend_down), 32'h04);
        tick(1);
        check("hall_here", 32'(call_here), 32'h1);
        door_open = 1'b1;
        tick(1);
        door_open = 1'b0;
        check("hall_up_clr", 32'(pend_up), 32'h0);
        check("hall_dn_keep", 32'(pend_down), 32'h04);
        check("hall_car_keep", 32'(pend_car), 32'h20);
        check("hall_dir_up", 32'(dir_req), 32'h1);

        // serve floor 5, reverse to the waiting down call
        floor_onehot = 6'b100000;
        door_open = 1'b1;
        tick(1);
        door_open = 1'b0;
        check("rev_car_clr", 32'(pend_car), 32'h0);
        check("rev_dir_down", 32'(dir_req), 32'h2);
        floor_onehot = 6'b000100;
        #1;
        check("rev_here", 32'(call_here), 32'h1);
        door_open = 1'b1;
        tick(1);
        door_open = 1'b0;
        check("rev_dn_clr", 32'(pend_down), 32'h0);
        check("rev_any", 32'(any_pending), 32'h0);
        check("rev_idle", 32'(dir_req), 32'h0);

        // scan priority: idle at floor 3, calls at 5 and 0
        floor_onehot = 6'b001000;
        btn_num_in = 6'b100001;
        tick(1);
        btn_num_in = '0;
        tick(2);
        check("scan_pend", 32'(pend_car), 32'h21);
        tick(1);
        check("scan_up_first", 32'(dir_req), 32'h1);
        floor_onehot = 6'b100000;
        door_open = 1'b1;
        tick(1);
        door_open = 1'b0;
        check("scan_after5", 32'(pend_car), 32'h01);
        check("scan_down", 32'(dir_req), 32'h2);
        floor_onehot = 6'b000001;
        door_open = 1'b1;
        tick(1);
        door_open = 1'b0;
        check("scan_done", 32'(pend_car), 32'h0);
        tick(1);
        check("scan_idle", 32'(dir_req), 32'h0);

        // ignored boundary hall buttons
        btn_up_out   = 6'b100000;
        btn_down_out = 6'b000001;
        tick(1);
        btn_up_out   = '0;
        btn_down_out = '0;
        tick(4);
        check("bnd_up5", 32'(pend_up), 32'h0);
        check("bnd_dn0", 32'(pend_down), 32'h0);
        check("bnd_any", 32'(any_pending), 32'h0);

        // invalid floor: no clears, stop, state held
        floor_onehot = 6'b000001;
        btn_num_in = 6'b000100;
        tick(1);
        btn_num_in = '0;
        tick(3);
        check("inv_dir_up", 32'(dir_req), 32'h1);
        floor_onehot = 6'b000000;
        door_open = 1'b1;
        #1;
        check("inv_dir_stop", 32'(dir_req), 32'h0);
        check("inv_here", 32'(call_here), 32'h0);
        tick(1);
        check("inv_no_clr", 32'(pend_car), 32'h04);
        floor_onehot = 6'b000101;
        tick(2);
        check("inv_multi_no_clr", 32'(pend_car), 32'h04);
        door_open = 1'b0;
        floor_onehot = 6'b100000;
        #1;
        check("inv_state_held", 32'(dir_req), 32'h1);
        tick(1);
        check("inv_then_down", 32'(dir_req), 32'h2);
        floor_onehot = 6'b000100;
        door_open = 1'b1;
        tick(1);
        check("inv_served", 32'(pend_car), 32'h0);
        tick(1);

        // press at current floor during a clear stays 0
        floor_onehot = 6'b000010;
        btn_num_in   = 6'b000010;
        btn_up_out   = 6'b000010;
        btn_down_out = 6'b000010;
        tick(1);
        btn_num_in   = '0;
        btn_up_out   = '0;
        btn_down_out = '0;
        tick(4);
        check("coinc_car", 32'(pend_car), 32'h0);
        check("coinc_up", 32'(pend_up), 32'h0);
        check("coinc_dn", 32'(pend_down), 32'h0);
        door_open = 1'b0;

        // asynchronous reset mid-cycle
        btn_num_in = 6'b010000;
        tick(1);
        btn_num_in = '0;
        tick(3);
        check("arst_pre", 32'(pend_car), 32'h10);
        #2;
        reset = 1'b0;
        #1;
        check("arst_clear", 32'(pend_car), 32'h0);
        check("arst_dir", 32'(dir_req), 32'h0);
        tick(1);
        reset = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
